// File: rtl/tone_gen.sv
// Beat-synchronised square-wave tone generator for the buzzer, clocked on in_clk.
// Optional build macro NOTE_GAP_EN inserts a silent gap at the start of every note.
module tone_gen #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int CNT_W      = 18,
  parameter int LATCH_DLY  = 4,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       beat_clk,
  input  logic [4:0] note,
  output logic       beep,
  output logic       note_active,
  output logic [4:0] cur_note
);

  localparam int DLY_W = (LATCH_DLY > 0) ? $clog2(LATCH_DLY + 1) : 1;
`ifdef NOTE_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REST = 2'd1,
    ST_TONE = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Half-period divisor per note code; rest codes map to zero.
  function automatic logic [CNT_W-1:0] half_of(input logic [4:0] code);
    case (code)
      5'd1:    half_of = CNT_W'(CLK_HZ / (2 * 262));
      5'd2:    half_of = CNT_W'(CLK_HZ / (2 * 294));
      5'd3:    half_of = CNT_W'(CLK_HZ / (2 * 330));
      5'd4:    half_of = CNT_W'(CLK_HZ / (2 * 349));
      5'd5:    half_of = CNT_W'(CLK_HZ / (2 * 392));
      5'd6:    half_of = CNT_W'(CLK_HZ / (2 * 440));
      5'd7:    half_of = CNT_W'(CLK_HZ / (2 * 494));
      5'd8:    half_of = CNT_W'(CLK_HZ / (2 * 523));
      5'd9:    half_of = CNT_W'(CLK_HZ / (2 * 587));
      5'd10:   half_of = CNT_W'(CLK_HZ / (2 * 659));
      5'd11:   half_of = CNT_W'(CLK_HZ / (2 * 698));
      5'd12:   half_of = CNT_W'(CLK_HZ / (2 * 784));
      5'd13:   half_of = CNT_W'(CLK_HZ / (2 * 880));
      5'd14:   half_of = CNT_W'(CLK_HZ / (2 * 988));
      5'd15:   half_of = CNT_W'(CLK_HZ / (2 * 1046));
      5'd16:   half_of = CNT_W'(CLK_HZ / (2 * 1175));
      5'd17:   half_of = CNT_W'(CLK_HZ / (2 * 1318));
      5'd18:   half_of = CNT_W'(CLK_HZ / (2 * 1397));
      5'd19:   half_of = CNT_W'(CLK_HZ / (2 * 1568));
      5'd20:   half_of = CNT_W'(CLK_HZ / (2 * 1760));
      5'd21:   half_of = CNT_W'(CLK_HZ / (2 * 1976));
      default: half_of = {CNT_W{1'b0}};
    endcase
  endfunction

  function automatic logic is_pitched(input logic [4:0] code);
    is_pitched = (code >= 5'd1) && (code <= 5'd21);
  endfunction

  logic             sync1_q, sync2_q, edge_q;
  logic             beat_tick_s;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             latch_s;
  logic [4:0]       cur_note_q, cur_note_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_s;
  logic             beep_q, beep_d;
  logic             note_active_q, note_active_d;
`ifdef NOTE_GAP_EN
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // beat_clk is asynchronous: two-flop synchronizer plus one flop for edge detection.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= beat_clk;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign beat_tick_s = sync2_q & ~edge_q;
  assign half_s      = half_of(cur_note_q);

  // Latch delay: a tick (re)arms the counter, the note is captured as it expires.
  always_comb begin
    dly_d      = dly_q;
    latch_s    = 1'b0;
    cur_note_d = cur_note_q;
    if (beat_tick_s) begin
      dly_d = DLY_W'(LATCH_DLY);
    end else if (dly_q != {DLY_W{1'b0}}) begin
      dly_d = dly_q - DLY_W'(1);
      if (dly_q == DLY_W'(1)) begin
        latch_s    = 1'b1;
        cur_note_d = note;
      end else begin
        cur_note_d = cur_note_q;
      end
    end else begin
      dly_d = dly_q;
    end
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      dly_q         <= {DLY_W{1'b0}};
      cur_note_q    <= 5'd0;
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      beep_q        <= 1'b0;
      note_active_q <= 1'b0;
`ifdef NOTE_GAP_EN
      gap_q         <= {GAP_W{1'b0}};
`endif
    end else begin
      dly_q         <= dly_d;
      cur_note_q    <= cur_note_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beep_q        <= beep_d;
      note_active_q <= note_active_d;
`ifdef NOTE_GAP_EN
      gap_q         <= gap_d;
`endif
    end
  end

  // Next-state logic; a latch always wins and restarts the phase from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;
`ifdef NOTE_GAP_EN
    gap_d   = gap_q;
`endif
    if (latch_s) begin
      cnt_d  = {CNT_W{1'b0}};
      beep_d = 1'b0;
`ifdef NOTE_GAP_EN
      state_d = ST_GAP;
      gap_d   = GAP_W'(GAP_CYCLES - 1);
`else
      state_d = is_pitched(note) ? ST_TONE : ST_REST;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_REST: begin
          cnt_d  = {CNT_W{1'b0}};
          beep_d = 1'b0;
        end
        ST_TONE: begin
          if (cnt_q == half_s - CNT_W'(1)) begin
            beep_d = ~beep_q;
            cnt_d  = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef NOTE_GAP_EN
        ST_GAP: begin
          cnt_d  = {CNT_W{1'b0}};
          beep_d = 1'b0;
          if (gap_q == {GAP_W{1'b0}}) begin
            state_d = is_pitched(cur_note_q) ? ST_TONE : ST_REST;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          beep_d  = 1'b0;
        end
      endcase
    end
`ifdef NOTE_GAP_EN
    note_active_d = (state_d == ST_TONE) || (state_d == ST_GAP);
`else
    note_active_d = (state_d == ST_TONE);
`endif
  end

  assign beep        = beep_q;
  assign note_active = note_active_q;
  assign cur_note    = cur_note_q;

endmodule

// File: tb/tb_tone_gen.sv
// Randomised bench for tone_gen against a time-based reference model of the tone rules.
module tb_tone_gen;

  localparam int CLK_HZ     = 500_000;
  localparam int CNT_W      = 18;
  localparam int LATCH_DLY  = 4;
  localparam int GAP_CYCLES = 100;
`ifdef NOTE_GAP_EN
  localparam int GAP_OFF = GAP_CYCLES;
`else
  localparam int GAP_OFF = 0;
`endif

  logic       in_clk   = 1'b0;
  logic       rst      = 1'b0;
  logic       beat_clk = 1'b0;
  logic [4:0] note     = 5'd0;
  logic       beep;
  logic       note_active;
  logic [4:0] cur_note;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: cycle count, latched code and the cycle it was latched.
  int unsigned cyc     = 0;
  int unsigned m_start = 0;
  logic        m_has   = 1'b0;
  logic [4:0]  m_code  = 5'd0;
  int unsigned lat_q[$];
  int          freq_tab[22] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                523, 587, 659, 698, 784, 880, 988,
                                1046, 1175, 1318, 1397, 1568, 1760, 1976};

  tone_gen #(
    .CLK_HZ    (CLK_HZ),
    .CNT_W     (CNT_W),
    .LATCH_DLY (LATCH_DLY),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .in_clk     (in_clk),
    .rst        (rst),
    .beat_clk   (beat_clk),
    .note       (note),
    .beep       (beep),
    .note_active(note_active),
    .cur_note   (cur_note)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      m_has  = 1'b0;
      m_code = 5'd0;
      lat_q.delete();
    end else begin
      cyc++;
      if (lat_q.size() > 0 && lat_q[0] == cyc) begin
        void'(lat_q.pop_front());
        m_has   = 1'b1;
        m_code  = note;
        m_start = cyc;
      end
    end
  end

  function automatic int unsigned half_ref(input logic [4:0] code);
    if (code > 5'd21 || code == 5'd0) return 0;
    return CLK_HZ / (2 * freq_tab[code]);
  endfunction

  function automatic logic [6:0] model_out();
    int unsigned e, h;
    logic b, a;
    if (!m_has) return 7'd0;
    e = cyc - m_start;
    h = half_ref(m_code);
    b = 1'b0;
    a = 1'b0;
    if (e < GAP_OFF) begin
      a = 1'b1;
    end else begin
      e = e - GAP_OFF;
      if (h != 0) begin
        a = 1'b1;
        b = ((e / h) % 2) == 1;
      end
    end
    return {b, a, m_code};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic cycle_chk();
    @(negedge in_clk);
    check("track", {25'd0, beep, note_active, cur_note}, {25'd0, model_out()});
  endtask

  task automatic run(input int n);
    repeat (n) cycle_chk();
  endtask

  // Raise beat_clk and record when the resulting latch is due; later ticks cancel it.
  task automatic rise();
    beat_clk = 1'b1;
    while (lat_q.size() > 0 && lat_q[$] >= cyc + 3) void'(lat_q.pop_back());
    lat_q.push_back(cyc + 3 + LATCH_DLY);
  endtask

  task automatic beat(input logic [4:0] code, input int high);
    note = code;
    rise();
    run(high);
    beat_clk = 1'b0;
  endtask

  initial begin
    int unsigned h;
    int          k;

    repeat (20) begin
      cycle_chk();
      beat_clk = 1'($urandom_range(0, 1));
      note     = 5'($urandom);
    end
    check("rst_beep", {31'd0, beep}, 32'd0);
    check("rst_active", {31'd0, note_active}, 32'd0);
    check("rst_cur", {27'd0, cur_note}, 32'd0);
    beat_clk = 1'b0;
    note     = 5'd0;
    cycle_chk();
    rst = 1'b1;
    run(5);

    // 880 Hz: latch at edge+3+LATCH_DLY, first rise HALF after the tone starts.
    h    = half_ref(5'd13);
    note = 5'd13;
    rise();
    run(3);
    beat_clk = 1'b0;
    run(3);
    check("t2_pre_latch", {27'd0, cur_note}, 32'd0);
    run(1);
    check("t2_latch", {27'd0, cur_note}, 32'd13);
    run(GAP_OFF + h - 1);
    check("t2_before_rise", {31'd0, beep}, 32'd0);
    run(1);
    check("t2_first_rise", {31'd0, beep}, 32'd1);
    check("t2_active", {31'd0, note_active}, 32'd1);
    run(3 * h);

    // Lowest note, then a rest.
    beat(5'd1, 5);
    run(GAP_OFF + 2100);
    beat(5'd0, 5);
    run(GAP_OFF + 10);
    check("t3_rest_beep", {31'd0, beep}, 32'd0);
    check("t3_rest_active", {31'd0, note_active}, 32'd0);

    // Mid-beat note change is ignored until the next beat; code 25 is a rest.
    beat(5'd8, 5);
    run(100);
    note = 5'd25;
    run(300);
    check("t4_hold", {27'd0, cur_note}, 32'd8);
    beat(5'd25, 5);
    run(GAP_OFF + 20);
    check("t4_cur", {27'd0, cur_note}, 32'd25);
    check("t4_beep", {31'd0, beep}, 32'd0);
    check("t4_active", {31'd0, note_active}, 32'd0);

    // Two rises two cycles apart give one latch, LATCH_DLY after the second tick.
    note = 5'd5;
    rise();
    run(1);
    beat_clk = 1'b0;
    note = 5'd6;
    run(1);
    rise();
    run(1);
    beat_clk = 1'b0;
    run(4);
    check("t5_no_first_latch", {27'd0, cur_note}, 32'd25);
    run(1);
    check("t5_not_yet", {27'd0, cur_note}, 32'd25);
    run(1);
    check("t5_latch", {27'd0, cur_note}, 32'd6);
    run(GAP_OFF + 500);

    // Same pitched code re-latched restarts the phase.
    beat(5'd13, 5);
    run(GAP_OFF + 400);
    beat(5'd13, 5);
    run(GAP_OFF + 700);

    // Highest note: silent for the gap (if built in), then HALF-cycle toggles.
    h    = half_ref(5'd21);
    note = 5'd21;
    rise();
    run(3);
    beat_clk = 1'b0;
    run(4 + GAP_OFF + h - 1);
    check("t6_before_rise", {31'd0, beep}, 32'd0);
    run(1);
    check("t6_first_rise", {31'd0, beep}, 32'd1);
    run(h);
    check("t6_first_fall", {31'd0, beep}, 32'd0);
    run(2 * h);

    // Random notes with occasional closely spaced double beats.
    for (int i = 0; i < 10; i++) begin
      beat(5'($urandom_range(0, 31)), $urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) begin
        run($urandom_range(1, 4));
        note = 5'($urandom_range(0, 31));
        rise();
        run($urandom_range(1, 3));
        beat_clk = 1'b0;
      end
      k = $urandom_range(50, 1200);
      run(k);
    end

    // Reset mid-note clears outputs at once; the first beat afterwards latches.
    beat(5'd20, 5);
    run(GAP_OFF + 500);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_beep", {31'd0, beep}, 32'd0);
    check("rst_mid_active", {31'd0, note_active}, 32'd0);
    check("rst_mid_cur", {27'd0, cur_note}, 32'd0);
    run(5);
    rst = 1'b1;
    run(3);
    beat(5'd17, 5);
    run(2);
    check("post_rst_latch", {27'd0, cur_note}, 32'd17);
    run(GAP_OFF + 600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
